// File: rtl/hw_regs_wr_arbiter.sv
// hw_regs_wr_arbiter: round-robin arbiter sharing the hardware-register RAM
// write port between NUM_REQ requesters. Each accepted 16-bit beat is turned
// into a registered cache-line write (WE, line address, replicated data,
// byte-lane mask). A requester may hold the grant with REQ_LOCK for atomic
// multi-word updates; an idle lock is broken after LOCK_TIMEOUT cycles.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   REQ_VALID/REQ_READY per-requester handshake (READY combinational, one-hot or zero)
//   REQ_LOCK            keep the grant after this beat
//   REQ_ADDR/DATA/BE    per-requester byte address, 16-bit data, byte enables
//   WE, ADDR_OUT, DATA_OUT, WMASK, GRANT_ID   registered line-write outputs
//   LOCKED              lock currently held
//   LOCK_ERR            one-cycle pulse when an idle lock is forcibly released
module hw_regs_wr_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned PORT_ADDR_SIZE  = 19,
  parameter int unsigned PORT_CACHE_BITS = 128,
  parameter int unsigned ENDIAN          = 1,
  parameter int unsigned HW_REGS_SIZE    = 14,
  parameter logic [PORT_ADDR_SIZE-1:0] BASE_WRITE_ADDRESS = '0,
  parameter int unsigned LOCK_TIMEOUT    = 64
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic [NUM_REQ-1:0]                     REQ_VALID,
  output logic [NUM_REQ-1:0]                     REQ_READY,
  input  logic [NUM_REQ-1:0]                     REQ_LOCK,
  input  logic [NUM_REQ-1:0][HW_REGS_SIZE-1:0]   REQ_ADDR,
  input  logic [NUM_REQ-1:0][15:0]               REQ_DATA,
  input  logic [NUM_REQ-1:0][1:0]                REQ_BE,
  output logic                                   WE,
  output logic [PORT_ADDR_SIZE-1:0]              ADDR_OUT,
  output logic [PORT_CACHE_BITS-1:0]             DATA_OUT,
  output logic [PORT_CACHE_BITS/8-1:0]           WMASK,
  output logic [2:0]                             GRANT_ID,
  output logic                                   LOCKED,
  output logic                                   LOCK_ERR
);

  localparam int unsigned LANES = PORT_CACHE_BITS / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned IW    = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(LOCK_TIMEOUT + 1);

  // Upper address bits come from the base; the register space fills the rest.
  localparam logic [PORT_ADDR_SIZE-1:0] BASE_HI =
    BASE_WRITE_ADDRESS & ~((PORT_ADDR_SIZE'(1) << HW_REGS_SIZE) - PORT_ADDR_SIZE'(1));
  localparam logic [HW_REGS_SIZE-1:0] LINE_MASK = ~HW_REGS_SIZE'(LANES - 1);
  localparam logic [LB-1:0]           ENDIAN_X  = LB'(ENDIAN);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               ptr_q, ptr_d;
  logic [IW-1:0]               owner_q, owner_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        we_q, we_d;
  logic [PORT_ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [PORT_CACHE_BITS-1:0]  data_q, data_d;
  logic [LANES-1:0]            wmask_q, wmask_d;
  logic [2:0]                  grant_q, grant_d;
  logic                        locked_q, locked_d;
  logic                        lock_err_q, lock_err_d;

  logic                        win_found;
  logic [IW-1:0]               win_idx;
  logic [IW:0]                 cand;
  logic                        accept;
  logic [IW-1:0]               sel_idx;
  logic [HW_REGS_SIZE-1:0]     a_sel;
  logic [15:0]                 d_sel;
  logic [1:0]                  be_sel;
  logic                        lock_sel;
  logic [LB-1:0]               k0, k1;

  // Round-robin scan: first valid requester after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (IW+1)'(ptr_q) + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_found && REQ_VALID[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state, handshake and output-register computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    wmask_d    = wmask_q;
    grant_d    = grant_q;
    lock_err_d = 1'b0;
    REQ_READY  = '0;
    accept     = 1'b0;
    sel_idx    = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          accept  = 1'b1;
          sel_idx = win_idx;
        end
      end
      ST_LOCKED: begin
        if (REQ_VALID[owner_q]) begin
          accept  = 1'b1;
          sel_idx = owner_q;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          // Owner went quiet for too long: break the lock, accept nothing now.
          state_d    = ST_IDLE;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No handshake is offered while reset is asserted.
    if (RESET) accept = 1'b0;

    a_sel    = REQ_ADDR[sel_idx];
    d_sel    = REQ_DATA[sel_idx];
    be_sel   = REQ_BE[sel_idx];
    lock_sel = REQ_LOCK[sel_idx];
    k0       = a_sel[LB-1:0] & ~LB'(1);
    k1       = k0 | LB'(1);

    if (accept) begin
      REQ_READY[sel_idx] = 1'b1;
      ptr_d              = sel_idx;
      cnt_d              = '0;
      // A beat with no byte enables completes the handshake but writes nothing.
      we_d               = |be_sel;
      addr_d             = BASE_HI | PORT_ADDR_SIZE'(a_sel & LINE_MASK);
      data_d             = {(LANES/2){d_sel}};
      wmask_d            = '0;
      wmask_d[k0 ^ ENDIAN_X] = be_sel[0];
      wmask_d[k1 ^ ENDIAN_X] = be_sel[1];
      grant_d            = 3'(sel_idx);
      if (lock_sel) begin
        state_d = ST_LOCKED;
        owner_d = sel_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers; reset drops any lock silently.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wmask_q    <= '0;
      grant_q    <= '0;
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wmask_q    <= wmask_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign WE       = we_q;
  assign ADDR_OUT = addr_q;
  assign DATA_OUT = data_q;
  assign WMASK    = wmask_q;
  assign GRANT_ID = grant_q;
  assign LOCKED   = locked_q;
  assign LOCK_ERR = lock_err_q;

endmodule

// File: doc/hw_regs_wr_arbiter.md
Name: hw_regs_wr_arbiter

Overview:
- Shares the single wide write port of the hardware-register RAM block between NUM_REQ requesters, e.g. the host bus bridge, the display-list loader and the debug/UART port.
- Each requester issues 16-bit register writes with byte enables over a valid/ready handshake.
- The arbiter picks requesters round-robin and converts each beat to the cache-line write format: WE, line address, replicated data and byte-lane WMASK.
- A lock lets one requester issue a multi-word update atomically, with a timeout guard.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- PORT_ADDR_SIZE, 19: width of ADDR_OUT.
- PORT_CACHE_BITS, 128: width of DATA_OUT; lane count LANES = PORT_CACHE_BITS/8, LB = log2(LANES).
- ENDIAN, 1: lane XOR applied to WMASK index (0, 1 or 3).
- HW_REGS_SIZE, 14: register-space address bits.
- BASE_WRITE_ADDRESS, 20'h0: base of the register space; bits [PORT_ADDR_SIZE-1:HW_REGS_SIZE] fill ADDR_OUT's upper bits.
- LOCK_TIMEOUT, 64: idle cycles allowed in LOCKED before a forced release (minimum 1).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  NUM_REQ  per-requester write valid
- REQ_READY  out  NUM_REQ  per-requester accept, one-hot or zero
- REQ_LOCK  in  NUM_REQ  hold grant after this beat
- REQ_ADDR  in  NUM_REQ x HW_REGS_SIZE  byte address (bit0 ignored)
- REQ_DATA  in  NUM_REQ x 16  [7:0] = even byte, [15:8] = odd byte
- REQ_BE  in  NUM_REQ x 2  byte enables: [0] even, [1] odd
- WE  out  1  write strobe
- ADDR_OUT  out  PORT_ADDR_SIZE  line address
- DATA_OUT  out  PORT_CACHE_BITS  write data
- WMASK  out  LANES  byte-lane mask
- GRANT_ID  out  3  requester index of the current WE beat
- LOCKED  out  1  lock held
- LOCK_ERR  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values: WE=0, ADDR_OUT=0, DATA_OUT=0, WMASK=0, GRANT_ID=0, LOCKED=0, LOCK_ERR=0.
- Reset state: IDLE, round-robin pointer=NUM_REQ-1 (requester 0 wins first), timeout counter=0.
- Reset forces REQ_READY=0 during the reset cycle.
- Handshake: REQ_READY is combinational from state, pointer and REQ_VALID. A beat transfers on cycle T when VALID&&READY. At most one READY is high per cycle.
- Requesters hold ADDR, DATA, BE and LOCK stable while VALID && !READY.
- Latency and throughput: outputs are registered. A beat accepted at T drives WE=1 at T+1 for exactly one cycle. Back-to-back accepts are allowed (one beat per cycle). WE=0 in any cycle following no accept.
- Output mapping for an accepted beat with address A:
  - ADDR_OUT = {BASE_WRITE_ADDRESS[PORT_ADDR_SIZE-1:HW_REGS_SIZE], A[HW_REGS_SIZE-1:LB], LB zeros}.
  - DATA_OUT = REQ_DATA replicated LANES/2 times (even lanes get [7:0], odd lanes get [15:8]).
  - k0 = {A[LB-1:1], 0} and k1 = k0 | 1.
  - WMASK bit (k0^ENDIAN) = BE[0], WMASK bit (k1^ENDIAN) = BE[1], all other bits 0.
  - GRANT_ID = winner index.
- BE=00: the beat is handshaken (READY=1) but WE stays 0 at T+1. The beat still counts for arbitration and lock.
- IDLE arbitration: the winner is the first valid requester scanning from pointer+1 modulo NUM_REQ. On accept, pointer=winner. If the accepted beat has LOCK=1, go to LOCKED with owner=winner and counter=0.
- LOCKED:
  - Only the owner may get READY; other requesters stall.
  - An owner beat with LOCK=1 stays LOCKED and clears the counter.
  - An owner beat with LOCK=0 is accepted, then the state returns to IDLE; the next cycle resumes round-robin from pointer=owner.
  - In a cycle with no owner VALID, the counter increments. When it reaches LOCK_TIMEOUT, go to IDLE and pulse LOCK_ERR=1 for one cycle; no beat is accepted that cycle. Arbitration resumes the following cycle.
  - LOCKED output = (state==LOCKED), registered.
- Reset mid-operation: a beat accepted in the reset cycle is discarded (WE stays 0). A held lock is dropped without LOCK_ERR.
- Simultaneous VALID from every requester with no locks: strict rotation 0,1,2,0,...

Test Plan:
- Defaults (LANES=16, ENDIAN=1). Req0 writes A=0x0012, D=0xABCD, BE=11 at T -> T+1: WE=1, ADDR_OUT=0x00010, WMASK=0x000C, DATA_OUT byte2=0xCD, byte3=0xAB, GRANT_ID=0. T+2: WE=0.
- Req1 writes A=0x0005, BE=01 -> WMASK=0x0020 (k0=4, bit 5), ADDR_OUT=0x00000. Req2 writes BE=00 -> READY=1 but no WE pulse.
- Req0, req1 and req2 VALID continuously for 6 cycles from reset -> GRANT_ID sequence 0,1,2,0,1,2 on consecutive WE cycles.
- Req1 sends 3 beats with LOCK=1,1,0 while req0 and req2 are VALID -> three consecutive WE with GRANT_ID=1 and LOCKED=1 during them; next grant is req2.
- LOCK_TIMEOUT=16: req0 sends a LOCK=1 beat, then drops VALID while req1 is VALID -> no WE for 16 cycles, then a LOCK_ERR pulse, then req1 granted the next cycle.
- Assert RESET during LOCKED with an owner beat handshaking -> no WE the following cycle, LOCKED=0, LOCK_ERR=0, next grant goes to the lowest-index valid requester.
